// File: rtl/opram_pkg.sv
// rtl/opram_pkg.sv - shared types and default constants for the op RAM sequencer
//
// Purpose: FSM state enum plus the default opcode width, address width and
//          halt opcode used as parameter defaults by opram_seq and opram_sdp.
// Ports:   none (package)
package opram_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int         DATA_W_DEF  = 8;
   localparam int         ADDR_W_DEF  = 3;
   localparam logic [7:0] HALT_OP_DEF = 8'hFF;

endpackage

// File: rtl/opram_sdp.sv
// rtl/opram_sdp.sv - simple dual-port synchronous RAM with write-first bypass
//
// Purpose: DATA_W x 2**ADDR_W storage, one write port and one enabled read
//          port with a registered read data output.
// Ports:   clk, rst (sync active-high, clears only the read register),
//          we/waddr/wdata (write port), re/raddr (read port),
//          rdata (registered read data, holds when re is low).
module opram_sdp
   import opram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Storage is deliberately not reset; a write in a reset cycle still lands.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Write-first: a same-cycle write to the read address is forwarded.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         if (we && (waddr == raddr)) begin
            rdata_d = wdata;
         end else begin
            rdata_d = mem[raddr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/opram_seq.sv
// rtl/opram_seq.sv - program-counter driven opcode sequencer over an op RAM
//
// Purpose: streams stored opcodes out under a program counter with a stall
//          input, stopping once the halt opcode has been accepted.
// Ports:   clk, rst (sync active-high)
//          write/waddr/writeop - host write port, usable in any state
//          start/start_addr    - begin a run from start_addr (IDLE only)
//          stall               - decoder not ready; freezes the op side
//          op/op_valid/op_pc   - current opcode, its valid flag and address
//          busy                - high while running
//          pc                  - next fetch address
module opram_seq
   import opram_pkg::*;
#(
   parameter int              DATA_W  = DATA_W_DEF,
   parameter int              ADDR_W  = ADDR_W_DEF,
   parameter logic [DATA_W-1:0] HALT_OP = DATA_W'(HALT_OP_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] writeop,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              stall,
   output logic [DATA_W-1:0] op,
   output logic              op_valid,
   output logic [ADDR_W-1:0] op_pc,
   output logic              busy,
   output logic [ADDR_W-1:0] pc
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] op_pc_q, op_pc_d;
   logic              op_valid_q, op_valid_d;
   logic              rd_en;
   logic              halt_seen;
   logic              halt_acc;

   opram_sdp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (write),
      .waddr (waddr),
      .wdata (writeop),
      .re    (rd_en),
      .raddr (pc_q),
      .rdata (op)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stall freezes the FSM, including a pending start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start && !stall) state_d = RUN;
         RUN:  if (halt_acc)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / control decode. A valid halt op blocks further fetches so the
   // pc stays parked one past the halt address.
   always_comb begin
      busy      = (state_q == RUN);
      halt_seen = op_valid_q && (op == HALT_OP);
      halt_acc  = halt_seen && !stall;
      rd_en     = busy && !stall && !halt_seen;
   end

   // Datapath next values
   always_comb begin
      pc_d       = pc_q;
      op_pc_d    = op_pc_q;
      op_valid_d = op_valid_q;
      if ((state_q == IDLE) && start && !stall) begin
         pc_d = start_addr;
      end
      if (rd_en) begin
         pc_d       = pc_q + ADDR_W'(1);
         op_pc_d    = pc_q;
         op_valid_d = 1'b1;
      end else if (op_valid_q && !stall) begin
         // accepted with nothing new behind it
         op_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= '0;
         op_pc_q    <= '0;
         op_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         op_pc_q    <= op_pc_d;
         op_valid_q <= op_valid_d;
      end
   end

   assign op_valid = op_valid_q;
   assign op_pc    = op_pc_q;
   assign pc       = pc_q;

endmodule

// File: tb/tb_opram_seq.sv
// tb/tb_opram_seq.sv - directed self-checking bench for opram_seq
//
// Purpose: drives host writes, runs, stalls, resets and stray starts and
//          compares the op stream against hand-computed expectations.
// Ports:   none (top-level bench)
module tb_opram_seq;

   logic       clk;
   logic       rst;
   logic       write;
   logic [2:0] waddr;
   logic [7:0] writeop;
   logic       start;
   logic [2:0] start_addr;
   logic       stall;
   logic [7:0] op;
   logic       op_valid;
   logic [2:0] op_pc;
   logic       busy;
   logic [2:0] pc;

   int n_assert = 0;
   int n_fail   = 0;

   // per-cycle trace of one run, index 0 is the cycle after the start pulse
   logic [7:0] tr_op   [40];
   logic       tr_v    [40];
   logic [2:0] tr_opc  [40];
   logic [2:0] tr_pc   [40];
   logic       tr_busy [40];
   logic [7:0] acc_op  [40];
   logic [2:0] acc_pc  [40];
   int         acc_n;
   int         end_k;
   bit         done;

   opram_seq dut (
      .clk        (clk),
      .rst        (rst),
      .write      (write),
      .waddr      (waddr),
      .writeop    (writeop),
      .start      (start),
      .start_addr (start_addr),
      .stall      (stall),
      .op         (op),
      .op_valid   (op_valid),
      .op_pc      (op_pc),
      .busy       (busy),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [2:0] a, input logic [7:0] d);
      write = 1'b1; waddr = a; writeop = d;
      cyc();
      write = 1'b0;
   endtask

   task automatic do_start(input logic [2:0] a);
      start = 1'b1; start_addr = a;
      cyc();
      start = 1'b0;
   endtask

   // Records outputs per cycle and the accepted op stream until busy drops.
   task automatic run_collect(input logic [39:0] smask, input int wk,
                              input logic [2:0] wa, input logic [7:0] wd,
                              input int sk, input logic [2:0] sa);
      acc_n = 0; done = 0; end_k = -1;
      for (int k = 0; k < 40; k++) begin
         stall = smask[k];
         write = (k == wk); waddr = wa; writeop = wd;
         start = (k == sk); start_addr = sa;
         tr_op[k] = op; tr_v[k] = op_valid; tr_opc[k] = op_pc;
         tr_pc[k] = pc; tr_busy[k] = busy;
         if (op_valid && !smask[k]) begin
            acc_op[acc_n] = op; acc_pc[acc_n] = op_pc; acc_n++;
         end
         if (!busy) begin
            done = 1; end_k = k;
            break;
         end
         cyc();
      end
      stall = 1'b0; write = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(); cyc();
      n_assert++; if (op !== 8'h00)   begin n_fail++; $display("FAIL reset_op got %h want 00", op); end
      n_assert++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", op_valid); end
      n_assert++; if (op_pc !== 3'd0) begin n_fail++; $display("FAIL reset_op_pc got %0d want 0", op_pc); end
      n_assert++; if (pc !== 3'd0)    begin n_fail++; $display("FAIL reset_pc got %0d want 0", pc); end
      n_assert++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic_run();
      logic [7:0] exp_op [4];
      exp_op = '{8'h11, 8'h22, 8'h33, 8'hFF};
      write_word(3'd0, 8'h11); write_word(3'd1, 8'h22);
      write_word(3'd2, 8'h33); write_word(3'd3, 8'hFF);
      do_start(3'd0);
      run_collect(40'd0, -1, 3'd0, 8'h00, -1, 3'd0);
      n_assert++; if (!done) begin n_fail++; $display("FAIL basic_timeout got busy still high want idle"); end
      n_assert++; if (tr_busy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_t1 got %b want 1", tr_busy[0]); end
      n_assert++; if (tr_pc[0] !== 3'd0) begin n_fail++; $display("FAIL basic_pc_t1 got %0d want 0", tr_pc[0]); end
      n_assert++; if (tr_v[0] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_t1 got %b want 0", tr_v[0]); end
      n_assert++; if (end_k !== 5) begin n_fail++; $display("FAIL basic_cycles got %0d want 5", end_k); end
      n_assert++; if (acc_n !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL basic_op[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
         n_assert++; if (acc_pc[i] !== 3'(i)) begin n_fail++; $display("FAIL basic_op_pc[%0d] got %0d want %0d", i, acc_pc[i], i); end
      end
      n_assert++; if (pc !== 3'd4) begin n_fail++; $display("FAIL basic_end_pc got %0d want 4", pc); end
      n_assert++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid got %b want 0", op_valid); end
   endtask

   task automatic test_stall();
      logic [7:0] exp_op [4];
      exp_op = '{8'h11, 8'h22, 8'h33, 8'hFF};
      do_start(3'd0);
      // stall during the three cycles where op first shows 22
      run_collect(40'b11100, -1, 3'd0, 8'h00, -1, 3'd0);
      n_assert++; if (!done) begin n_fail++; $display("FAIL stall_timeout got busy still high want idle"); end
      for (int k = 2; k <= 5; k++) begin
         n_assert++;
         if (tr_op[k] !== 8'h22 || tr_v[k] !== 1'b1 || tr_opc[k] !== 3'd1 || tr_pc[k] !== 3'd2) begin
            n_fail++;
            $display("FAIL stall_hold[%0d] got op=%h v=%b op_pc=%0d pc=%0d want op=22 v=1 op_pc=1 pc=2",
                     k, tr_op[k], tr_v[k], tr_opc[k], tr_pc[k]);
         end
      end
      n_assert++; if (tr_op[6] !== 8'h33) begin n_fail++; $display("FAIL stall_resume got %h want 33", tr_op[6]); end
      n_assert++; if (acc_n !== 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL stall_op[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
      end
      n_assert++; if (end_k !== 8) begin n_fail++; $display("FAIL stall_cycles got %0d want 8", end_k); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_op [8];
      logic [2:0] exp_pc [8];
      exp_op = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01, 8'h02, 8'hFF};
      exp_pc = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
      write_word(3'd0, 8'h01); write_word(3'd1, 8'h02);
      write_word(3'd2, 8'hFF); write_word(3'd3, 8'h04);
      write_word(3'd4, 8'h05); write_word(3'd5, 8'h06);
      write_word(3'd6, 8'h07); write_word(3'd7, 8'h08);
      do_start(3'd3);
      run_collect(40'd0, -1, 3'd0, 8'h00, -1, 3'd0);
      n_assert++; if (!done) begin n_fail++; $display("FAIL wrap_timeout got busy still high want idle"); end
      n_assert++; if (acc_n !== 8) begin n_fail++; $display("FAIL wrap_count got %0d want 8", acc_n); end
      for (int i = 0; i < 8; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL wrap_op[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
         n_assert++; if (acc_pc[i] !== exp_pc[i]) begin n_fail++; $display("FAIL wrap_op_pc[%0d] got %0d want %0d", i, acc_pc[i], exp_pc[i]); end
      end
      n_assert++; if (pc !== 3'd3) begin n_fail++; $display("FAIL wrap_end_pc got %0d want 3", pc); end
   endtask

   task automatic test_write_first();
      logic [7:0] exp_op [4];
      exp_op = '{8'h11, 8'hAA, 8'h33, 8'hFF};
      write_word(3'd0, 8'h11); write_word(3'd1, 8'h22);
      write_word(3'd2, 8'h33); write_word(3'd3, 8'hFF);
      do_start(3'd0);
      // in cycle 1 the fetch address is 1; overwrite it in the same cycle
      run_collect(40'd0, 1, 3'd1, 8'hAA, -1, 3'd0);
      n_assert++; if (acc_n !== 4) begin n_fail++; $display("FAIL wf_count got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL wf_op[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] exp_op [4];
      exp_op = '{8'h11, 8'hAA, 8'h55, 8'hFF};
      do_start(3'd0);
      cyc(); cyc();
      n_assert++; if (op_valid !== 1'b1 || busy !== 1'b1 || op !== 8'hAA) begin
         n_fail++; $display("FAIL rstmid_pre got v=%b busy=%b op=%h want v=1 busy=1 op=aa", op_valid, busy, op);
      end
      rst = 1'b1; write = 1'b1; waddr = 3'd2; writeop = 8'h55;
      cyc();
      rst = 1'b0; write = 1'b0;
      n_assert++; if (op !== 8'h00) begin n_fail++; $display("FAIL rstmid_op got %h want 00", op); end
      n_assert++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", op_valid); end
      n_assert++; if (pc !== 3'd0) begin n_fail++; $display("FAIL rstmid_pc got %0d want 0", pc); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_assert++; if (op_pc !== 3'd0) begin n_fail++; $display("FAIL rstmid_op_pc got %0d want 0", op_pc); end
      do_start(3'd0);
      run_collect(40'd0, -1, 3'd0, 8'h00, -1, 3'd0);
      n_assert++; if (acc_n !== 4) begin n_fail++; $display("FAIL rstmid_count got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL rstmid_mem[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
      end
   endtask

   task automatic test_start_ignored();
      logic [7:0] exp_op [4];
      exp_op = '{8'h11, 8'hAA, 8'h55, 8'hFF};
      do_start(3'd0);
      run_collect(40'd0, -1, 3'd0, 8'h00, 2, 3'd5);
      n_assert++; if (!done) begin n_fail++; $display("FAIL startign_timeout got busy still high want idle"); end
      n_assert++; if (tr_pc[3] !== 3'd3) begin n_fail++; $display("FAIL startign_pc got %0d want 3", tr_pc[3]); end
      n_assert++; if (end_k !== 5) begin n_fail++; $display("FAIL startign_cycles got %0d want 5", end_k); end
      n_assert++; if (acc_n !== 4) begin n_fail++; $display("FAIL startign_count got %0d want 4", acc_n); end
      for (int i = 0; i < 4; i++) begin
         n_assert++; if (acc_op[i] !== exp_op[i]) begin n_fail++; $display("FAIL startign_op[%0d] got %h want %h", i, acc_op[i], exp_op[i]); end
         n_assert++; if (acc_pc[i] !== 3'(i)) begin n_fail++; $display("FAIL startign_op_pc[%0d] got %0d want %0d", i, acc_pc[i], i); end
      end
   endtask

   initial begin
      rst = 1'b1; write = 1'b0; waddr = '0; writeop = '0;
      start = 1'b0; start_addr = '0; stall = 1'b0;
      test_reset();
      test_basic_run();
      test_stall();
      test_wrap();
      test_write_first();
      test_reset_mid_run();
      test_start_ignored();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
